// File: rtl/first8_lane_scheduler.sv
// Round-robin dispatcher of frames onto NLANES fixed-latency encoder lanes; results merged onto one tagged stream.
// Grant pulse 1 cycle after frame_valid, result LAT cycles later; frames arriving with every lane busy are dropped and counted.
module first8_lane_scheduler #(
    parameter int NLANES = 2,
    parameter int LAT    = 8,
    parameter int TAGW   = 12,
    parameter int OVFW   = 16,
    localparam int SELW  = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic              clock4x,
    input  logic              global_reset_n,
    input  logic              sched_en,
    input  logic              frame_valid,
    input  logic [TAGW-1:0]   frame_tag,
    output logic [NLANES-1:0] lane_go,
    output logic              out_valid,
    output logic [SELW-1:0]   out_sel,
    output logic [TAGW-1:0]   out_tag,
    output logic [NLANES-1:0] lanes_busy,
    output logic              overflow,
    output logic [OVFW-1:0]   overflow_cnt
);

    logic [3:0]      cnt   [NLANES];
    logic [TAGW-1:0] tag_q [NLANES];
    logic [SELW-1:0] rr;

    logic            found;
    logic [SELW-1:0] pick;
    logic            done_any;
    logic [SELW-1:0] done_sel;
    logic            grant;
    logic            drop;

    // First free lane at or after rr, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NLANES; k++) begin
            idx = int'(rr) + k;
            if (idx >= NLANES) begin
                idx = idx - NLANES;
            end
            if (!found && !lanes_busy[idx]) begin
                found = 1'b1;
                pick  = SELW'(idx);
            end
        end
    end

    // A lane whose counter reaches 1 finishes this cycle; one grant per cycle keeps these exclusive.
    always_comb begin
        done_any = 1'b0;
        done_sel = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (cnt[i] == 4'd1) begin
                done_any = 1'b1;
                done_sel = SELW'(i);
            end
        end
    end

    assign grant = frame_valid && sched_en && found;
    assign drop  = frame_valid && sched_en && !found;

    always_ff @(posedge clock4x) begin
        if (!global_reset_n) begin
            lane_go      <= '0;
            out_valid    <= 1'b0;
            out_sel      <= '0;
            out_tag      <= '0;
            lanes_busy   <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= '0;
            rr           <= '0;
            for (int i = 0; i < NLANES; i++) begin
                cnt[i]   <= 4'd0;
                tag_q[i] <= '0;
            end
        end else begin
            lane_go   <= '0;
            out_valid <= done_any;
            overflow  <= drop;

            if (done_any) begin
                out_sel <= done_sel;
                out_tag <= tag_q[done_sel];
            end

            for (int i = 0; i < NLANES; i++) begin
                if (grant && pick == SELW'(i)) begin
                    cnt[i]        <= 4'(LAT);
                    lanes_busy[i] <= 1'b1;
                    tag_q[i]      <= frame_tag;
                end else if (cnt[i] != 4'd0) begin
                    cnt[i] <= cnt[i] - 4'd1;
                    if (cnt[i] == 4'd1) begin
                        lanes_busy[i] <= 1'b0;
                    end
                end
            end

            if (grant) begin
                lane_go[pick] <= 1'b1;
                rr <= (pick == SELW'(NLANES - 1)) ? '0 : pick + SELW'(1);
            end

            if (drop && overflow_cnt != {OVFW{1'b1}}) begin
                overflow_cnt <= overflow_cnt + OVFW'(1);
            end
        end
    end

endmodule

// File: tb/tb_first8_lane_scheduler.sv
// Directed bench: a time-stamp model of lane occupancy checked every cycle, plus hand-computed literal points.
// A second instance with a 4-bit drop counter exercises saturation in a handful of cycles.
module tb_first8_lane_scheduler;

    localparam int NL   = 2;
    localparam int LATP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sched_en;
    logic        fv;
    logic [11:0] ftag;

    logic [1:0]  lane_go, lanes_busy, lane_go_s, lanes_busy_s;
    logic        out_valid, overflow, out_valid_s, overflow_s;
    logic [0:0]  out_sel, out_sel_s;
    logic [11:0] out_tag, out_tag_s;
    logic [15:0] overflow_cnt;
    logic [3:0]  overflow_cnt_s;

    int n_chk = 0;
    int n_err = 0;
    int lc    = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    first8_lane_scheduler #(.NLANES(NL), .LAT(LATP), .TAGW(12), .OVFW(16)) dut (
        .clock4x(clk), .global_reset_n(rst_n), .sched_en(sched_en),
        .frame_valid(fv), .frame_tag(ftag), .lane_go(lane_go),
        .out_valid(out_valid), .out_sel(out_sel), .out_tag(out_tag),
        .lanes_busy(lanes_busy), .overflow(overflow), .overflow_cnt(overflow_cnt)
    );

    first8_lane_scheduler #(.NLANES(NL), .LAT(LATP), .TAGW(12), .OVFW(4)) dut_s (
        .clock4x(clk), .global_reset_n(rst_n), .sched_en(sched_en),
        .frame_valid(fv), .frame_tag(ftag), .lane_go(lane_go_s),
        .out_valid(out_valid_s), .out_sel(out_sel_s), .out_tag(out_tag_s),
        .lanes_busy(lanes_busy_s), .overflow(overflow_s), .overflow_cnt(overflow_cnt_s)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at lc=%0d: got %0h expected %0h", nm, lc, got, exp);
        end
    endtask

    // Model: each lane is described by the absolute cycle at which it becomes free again.
    int          now_c = 0;
    int          free_at [NL];
    bit          inflight [NL];
    logic [11:0] m_tag [NL];
    int          rr_m;
    logic [1:0]  e_go, e_busy;
    logic        e_valid, e_ovf;
    int          e_sel;
    logic [11:0] e_tag;
    int          e_cnt, e_cnt_s;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NL; g++) begin
                free_at[g]  = now_c;
                inflight[g] = 1'b0;
            end
            rr_m = 0; e_go = '0; e_busy = '0; e_valid = 1'b0; e_ovf = 1'b0;
            e_sel = 0; e_tag = '0; e_cnt = 0; e_cnt_s = 0;
        end else begin
            int g_pick;
            g_pick = -1;
            e_go = '0; e_ovf = 1'b0; e_valid = 1'b0;
            if (fv && sched_en) begin
                for (int k = 0; k < NL; k++) begin
                    int g;
                    g = (rr_m + k) % NL;
                    if (g_pick < 0 && now_c >= free_at[g]) g_pick = g;
                end
                if (g_pick >= 0) begin
                    e_go             = 2'(1 << g_pick);
                    free_at[g_pick]  = now_c + 1 + LATP;
                    inflight[g_pick] = 1'b1;
                    m_tag[g_pick]    = ftag;
                    rr_m             = (g_pick + 1) % NL;
                end else begin
                    e_ovf = 1'b1;
                    if (e_cnt < 16'hFFFF) e_cnt++;
                    if (e_cnt_s < 15) e_cnt_s++;
                end
            end
            for (int g = 0; g < NL; g++) begin
                if (inflight[g] && free_at[g] == now_c + 1) begin
                    e_valid     = 1'b1;
                    e_sel       = g;
                    e_tag       = m_tag[g];
                    inflight[g] = 1'b0;
                end
                e_busy[g] = (now_c + 1 < free_at[g]);
            end
        end
        now_c++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("go",      32'(lane_go),        32'(e_go));
            chk("valid",   32'(out_valid),      32'(e_valid));
            chk("sel",     32'(out_sel),        32'(e_sel));
            chk("tag",     32'(out_tag),        32'(e_tag));
            chk("busy",    32'(lanes_busy),     32'(e_busy));
            chk("ovf",     32'(overflow),       32'(e_ovf));
            chk("cnt",     32'(overflow_cnt),   32'(e_cnt));
            chk("valid_s", 32'(out_valid_s),    32'(e_valid));
            chk("ovf_s",   32'(overflow_s),     32'(e_ovf));
            chk("cnt_s",   32'(overflow_cnt_s), 32'(e_cnt_s));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fv = 1'b0; sched_en = 1'b1; ftag = '0;
        step();
        step();
        rst_n = 1'b1;
        lc = 0;
    endtask

    initial begin
        rst_n = 1'b0; sched_en = 1'b1; fv = 1'b0; ftag = '0;

        // Test 1: spacing of 5 keeps each lane's 9-cycle turnaround clear, so lanes simply alternate.
        do_reset();
        chk_en = 1'b1;
        chk("rst_go",    32'(lane_go), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy",  32'(lanes_busy), 0);
        chk("rst_cnt",   32'(overflow_cnt), 0);
        for (int c = 0; c < 28; c++) begin
            fv = (c % 5 == 0) && (c < 20);
            ftag = 12'(c / 5 + 1);
            step();
            if (lc == 1 || lc == 11) chk("t1_go", 32'(lane_go), 1);
            if (lc == 6 || lc == 16) chk("t1_go", 32'(lane_go), 2);
            if (lc % 5 == 4 && lc >= 9 && lc <= 24) begin
                chk("t1_valid", 32'(out_valid), 1);
                chk("t1_tag",   32'(out_tag), 32'((lc - 4) / 5));
                chk("t1_sel",   32'(out_sel), 32'(((lc - 9) / 5) % 2));
            end
        end
        fv = 1'b0;
        chk("t1_cnt", 32'(overflow_cnt), 0);

        // Test 2: third frame finds both lanes busy.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            fv = (c == 0 || c == 2 || c == 4);
            ftag = 12'(c + 16);
            step();
            if (lc == 3) chk("t2_go", 32'(lane_go), 2);
            if (lc == 5) chk("t2_ovf", 32'(overflow), 1);
            if (lc == 6) chk("t2_cnt", 32'(overflow_cnt), 1);
            if (lc == 9) begin
                chk("t2_valid9", 32'(out_valid), 1);
                chk("t2_tag9",   32'(out_tag), 16);
            end
            if (lc == 10) chk("t2_valid10", 32'(out_valid), 0);
            if (lc == 11) begin
                chk("t2_valid11", 32'(out_valid), 1);
                chk("t2_sel11",   32'(out_sel), 1);
                chk("t2_tag11",   32'(out_tag), 18);
            end
        end
        fv = 1'b0;

        // Test 3: rr has moved to lane 1, which wins even though lane 0 is free again.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            fv = (c == 0 || c == 9);
            ftag = 12'(c + 32);
            step();
            if (lc == 9) chk("t3_sel9", 32'(out_sel), 0);
            if (lc == 10) chk("t3_go", 32'(lane_go), 2);
            if (lc == 18) begin
                chk("t3_valid", 32'(out_valid), 1);
                chk("t3_sel",   32'(out_sel), 1);
                chk("t3_tag",   32'(out_tag), 41);
            end
        end
        fv = 1'b0;

        // Test 4: scheduler disabled while lane 0 is in flight.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            fv = (c == 0 || c == 3 || c == 5);
            sched_en = (c < 2);
            ftag = 12'(c + 48);
            step();
            if (lc == 4) begin
                chk("t4_busy", 32'(lanes_busy), 1);
                chk("t4_go",   32'(lane_go), 0);
            end
            if (lc == 9) begin
                chk("t4_valid", 32'(out_valid), 1);
                chk("t4_tag",   32'(out_tag), 48);
            end
            if (lc == 12) chk("t4_cnt", 32'(overflow_cnt), 0);
        end
        fv = 1'b0;
        sched_en = 1'b1;

        // Test 6: continuous frames; 17 drops, the 4-bit counter sticks at 15.
        do_reset();
        for (int c = 0; c < 31; c++) begin
            fv = (c <= 22);
            ftag = 12'(c + 80);
            step();
            if (lc == 18) begin
                chk("t6_cnt18",   32'(overflow_cnt), 14);
                chk("t6_cnt_s18", 32'(overflow_cnt_s), 14);
            end
            if (lc == 22) chk("t6_ovf_s", 32'(overflow_s), 1);
            if (lc == 23) begin
                chk("t6_cnt23",   32'(overflow_cnt), 17);
                chk("t6_cnt_s23", 32'(overflow_cnt_s), 15);
            end
            if (lc == 28) chk("t6_tag28", 32'(out_tag), 99);
        end
        fv = 1'b0;

        // Test 5: reset mid-flight wipes counters, held result fields and the pending result.
        lc = 0;
        for (int c = 0; c < 13; c++) begin
            fv = (c == 0);
            rst_n = (c != 5);
            ftag = 12'd64;
            step();
            if (lc == 3) chk("t5_busy3", 32'(lanes_busy), 1);
            if (lc == 6) begin
                chk("t5_busy",  32'(lanes_busy), 0);
                chk("t5_sel",   32'(out_sel), 0);
                chk("t5_tag",   32'(out_tag), 0);
                chk("t5_cnt",   32'(overflow_cnt), 0);
                chk("t5_cnt_s", 32'(overflow_cnt_s), 0);
            end
            if (lc == 9) chk("t5_valid9", 32'(out_valid), 0);
        end
        fv = 1'b0;
        rst_n = 1'b1;

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
